ldpc_dec_ctrl: RTL and testbench
================================

Name: ldpc_dec_ctrl

Overview:
- Top-level sequencing FSM of the LDPC decoder; sits directly upstream of the read-address generator.
- Drives the one-hot phase vector fsm[3:0] and the 2-bit sub-cycle counter cycle that the address generators and the check/variable-node units consume.
- Handles frame load, iterates check-node (CNU) and variable-node (VNU) phases up to a programmable limit with early termination, then unloads the hard decisions.

Parameters:
- CNU_GRP_R0, 128, CNU groups per iteration at rate=0 (each group = 4 cycles).
- CNU_GRP_R1, 64, CNU groups per iteration at rate=1.
- VNU_GRP, 256, VNU groups per iteration (4 cycles each).
- LOAD_LEN, 256, LLR input beats per frame.
- OUT_LEN, 128, hard-decision output beats per frame.
- CNT_W, 9, width of the internal beat/group counters; must hold max(LOAD_LEN, OUT_LEN, VNU_GRP).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  one-cycle frame start request
- rate  in  1  code rate select, latched on accepted start
- max_iter  in  5  iteration limit, latched on accepted start; 0 treated as 1
- in_valid  in  1  LLR beat valid
- in_ready  out  1  LLR beat accepted when in_valid && in_ready
- parity_ok  in  1  syndrome-zero flag from the check units, sampled on the last VNU cycle
- out_valid  out  1  hard-decision beat valid
- out_ready  in  1  downstream accepts beat
- fsm  out  4  one-hot phase: [0] LOAD, [1] VNU, [2] CNU (read enable), [3] OUT; 4'b0000 = IDLE
- cycle  out  2  sub-cycle within a group, 0..3
- iter_cnt  out  5  completed iterations of the current frame
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on the OUT->IDLE transition
- early_term  out  1  registered; set when the frame ended on parity_ok; cleared on next accepted start

Behaviour:
- All outputs are registered. Reset (async, any time, including mid-frame) forces IDLE: fsm=0, cycle=0, iter_cnt=0, busy=0, done=0, early_term=0, in_ready=0, out_valid=0, all counters=0.
- IDLE: start=1 -> LOAD next cycle; rate and max_iter latched; early_term cleared. start is ignored in every other state.
- LOAD: in_ready=1. The beat counter increments on each accepted beat. On the LOAD_LEN-th accepted beat -> CNU. in_ready drops in the same cycle fsm leaves LOAD.
- CNU: cycle increments 0,1,2,3,0,... every clock, starting at 0 on entry. The group counter increments when cycle==3. When cycle==3 and group==cnu_len-1 -> VNU. cnu_len = CNU_GRP_R1 if the latched rate is 1, else CNU_GRP_R0. A CNU phase therefore lasts exactly 4*cnu_len cycles.
- VNU: same cycle and group rules with VNU_GRP. On its final cycle (cycle==3, group==VNU_GRP-1):
  - iter_cnt increments.
  - If parity_ok==1, -> OUT and early_term set.
  - Else if the new iter_cnt == effective max_iter, -> OUT.
  - Else -> CNU, with cycle and group restarting at 0.
  - parity_ok is ignored on all other cycles.
- OUT: out_valid=1. The beat counter increments on out_valid && out_ready. On the OUT_LEN-th accepted beat -> IDLE with done=1 for that single cycle. out_valid holds while out_ready=0 (no timeout).
- cycle is 0 whenever fsm is not CNU or VNU.
- iter_cnt holds its final value in IDLE until the next accepted start, which zeroes it.
- Counters are CNT_W bits wide and never wrap within a phase; each is cleared on phase entry.

Test Plan:
- Reset mid-CNU (assert reset while fsm=4'b0100, cycle=2) -> fsm=0, cycle=0, busy=0 asynchronously; the next start runs a full frame normally.
- Params LOAD_LEN=4, CNU_GRP_R0=2, VNU_GRP=2, OUT_LEN=2; rate=0, max_iter=3, parity_ok=0, in_valid and out_ready held high -> 4 LOAD cycles, three CNU(8)/VNU(8) rounds, iter_cnt=3, 2 OUT beats, done pulse, early_term=0.
- Same setup, parity_ok=1 only on the last VNU cycle of iteration 2 -> OUT entered after iter_cnt=2, early_term=1.
- rate=1 with CNU_GRP_R1=1 -> CNU phase lasts exactly 4 cycles, cycle sequence 0,1,2,3.
- max_iter=0 -> exactly one iteration runs, iter_cnt=1.
- in_valid toggled 1,0,1,0,... in LOAD and out_ready toggled in OUT -> counts advance only on handshake beats; start pulsed during CNU is ignored; a single-cycle done pulse occurs.

Source files
------------

// File: rtl/ldpc_dec_ctrl.sv
// rtl/ldpc_dec_ctrl.sv - LDPC decoder top-level sequencing FSM
// Drives one-hot phase vector and sub-cycle counter through load, CNU/VNU iterations and unload.
module ldpc_dec_ctrl #(
  parameter int CNU_GRP_R0 = 128,
  parameter int CNU_GRP_R1 = 64,
  parameter int VNU_GRP    = 256,
  parameter int LOAD_LEN   = 256,
  parameter int OUT_LEN    = 128,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rate,
  input  logic [4:0] max_iter,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       parity_ok,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fsm,
  output logic [1:0] cycle,
  output logic [4:0] iter_cnt,
  output logic       busy,
  output logic       done,
  output logic       early_term
);

  // State encoding doubles as the one-hot phase vector, so fsm comes straight off the flops.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_LOAD = 4'b0001,
    S_VNU  = 4'b0010,
    S_CNU  = 4'b0100,
    S_OUT  = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST    = CNT_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0] VNU_LAST    = CNT_W'(VNU_GRP - 1);
  localparam logic [CNT_W-1:0] CNU_R0_LAST = CNT_W'(CNU_GRP_R0 - 1);
  localparam logic [CNT_W-1:0] CNU_R1_LAST = CNT_W'(CNU_GRP_R1 - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnu_last;
  logic [1:0]       cycle_nxt;
  logic [4:0]       iter_nxt;
  logic [4:0]       max_eff, max_eff_nxt;
  logic             rate_q, rate_nxt;
  logic             early_nxt;

  assign fsm      = state;
  assign cnu_last = rate_q ? CNU_R1_LAST : CNU_R0_LAST;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cycle_nxt   = 2'd0;
    iter_nxt    = iter_cnt;
    max_eff_nxt = max_eff;
    rate_nxt    = rate_q;
    early_nxt   = early_term;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_LOAD;
          cnt_nxt     = '0;
          rate_nxt    = rate;
          max_eff_nxt = (max_iter == 5'd0) ? 5'd1 : max_iter;
          iter_nxt    = 5'd0;
          early_nxt   = 1'b0;
        end
      end
      // in_ready is high for every LOAD cycle, so in_valid alone marks a beat.
      S_LOAD: begin
        if (in_valid) begin
          if (cnt == LOAD_LAST) begin
            state_nxt = S_CNU;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_CNU: begin
        cycle_nxt = cycle + 2'd1;
        if (cycle == 2'd3) begin
          if (cnt == cnu_last) begin
            state_nxt = S_VNU;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_VNU: begin
        cycle_nxt = cycle + 2'd1;
        if (cycle == 2'd3) begin
          if (cnt == VNU_LAST) begin
            cnt_nxt  = '0;
            iter_nxt = iter_cnt + 5'd1;
            if (parity_ok) begin
              state_nxt = S_OUT;
              early_nxt = 1'b1;
            end else if (iter_nxt == max_eff) begin
              state_nxt = S_OUT;
            end else begin
              state_nxt = S_CNU;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt == OUT_LAST) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cycle      <= 2'd0;
      iter_cnt   <= 5'd0;
      max_eff    <= 5'd1;
      rate_q     <= 1'b0;
      early_term <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cycle      <= cycle_nxt;
      iter_cnt   <= iter_nxt;
      max_eff    <= max_eff_nxt;
      rate_q     <= rate_nxt;
      early_term <= early_nxt;
      in_ready   <= (state_nxt == S_LOAD);
      out_valid  <= (state_nxt == S_OUT);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state == S_OUT) && (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// tb/tb_ldpc_dec_ctrl.sv - directed self-checking bench for ldpc_dec_ctrl
module tb_ldpc_dec_ctrl;

  localparam int LOAD_LEN   = 4;
  localparam int CNU_GRP_R0 = 2;
  localparam int CNU_GRP_R1 = 1;
  localparam int VNU_GRP    = 2;
  localparam int OUT_LEN    = 2;
  localparam int CNT_W      = 9;

  localparam logic [3:0] P_IDLE = 4'b0000;
  localparam logic [3:0] P_LOAD = 4'b0001;
  localparam logic [3:0] P_VNU  = 4'b0010;
  localparam logic [3:0] P_CNU  = 4'b0100;
  localparam logic [3:0] P_OUT  = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rate;
  logic [4:0] max_iter;
  logic       in_valid;
  logic       in_ready;
  logic       parity_ok;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fsm;
  logic [1:0] cycle;
  logic [4:0] iter_cnt;
  logic       busy;
  logic       done;
  logic       early_term;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ldpc_dec_ctrl #(
    .CNU_GRP_R0(CNU_GRP_R0),
    .CNU_GRP_R1(CNU_GRP_R1),
    .VNU_GRP   (VNU_GRP),
    .LOAD_LEN  (LOAD_LEN),
    .OUT_LEN   (OUT_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rate      (rate),
    .max_iter  (max_iter),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .parity_ok (parity_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fsm       (fsm),
    .cycle     (cycle),
    .iter_cnt  (iter_cnt),
    .busy      (busy),
    .done      (done),
    .early_term(early_term)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame from IDLE; inputs for the current cycle are set at each negedge after sampling.
  task automatic run_frame(input string name, input logic r, input logic [4:0] mi,
                           input int par_iter, input bit noise, input bit toggle, input bit start_mid,
                           input int exp_load, input int exp_cnu, input int exp_vnu, input int exp_out,
                           input int exp_iter, input int exp_early);
    int n_load = 0, n_cnu = 0, n_vnu = 0, n_out = 0;
    int n_inbeat = 0, n_outbeat = 0, bad = 0, vnu_ph = 0, idx = 0, done_seen = 0;
    logic [3:0] prev = P_IDLE;
    bit finished = 0;
    bit first = 1;
    @(negedge clk);
    start = 1'b1; rate = r; max_iter = mi;
    in_valid = 1'b1; out_ready = !toggle; parity_ok = 1'b0;
    for (int t = 0; t < 2000 && !finished; t++) begin
      @(negedge clk);
      start = 1'b0; rate = ~r; max_iter = 5'd7;
      if (fsm != prev) idx = 0; else idx++;
      if (fsm == P_VNU && fsm != prev) vnu_ph++;
      prev = fsm;
      if (first) begin
        check({name, "_first_fsm"}, fsm, P_LOAD);
        check({name, "_iter_clr"}, iter_cnt, 0);
        check({name, "_early_clr"}, early_term, 0);
        first = 0;
      end
      case (fsm)
        P_LOAD: n_load++;
        P_CNU:  n_cnu++;
        P_VNU:  n_vnu++;
        P_OUT:  n_out++;
        P_IDLE: finished = 1;
        default: bad++;
      endcase
      if (fsm == P_CNU || fsm == P_VNU) begin
        if (cycle != idx[1:0]) bad++;
      end else if (cycle != 2'd0) bad++;
      if (in_ready != (fsm == P_LOAD)) bad++;
      if (out_valid != (fsm == P_OUT)) bad++;
      if (busy != (fsm != P_IDLE)) bad++;
      if (done) done_seen++;
      in_valid  = toggle ? ((fsm == P_LOAD) ? !idx[0] : 1'b0) : 1'b1;
      out_ready = toggle ? ((fsm == P_OUT) ? idx[0] : 1'b0) : 1'b1;
      if (fsm == P_LOAD && in_valid) n_inbeat++;
      if (fsm == P_OUT && out_ready) n_outbeat++;
      parity_ok = (fsm == P_VNU) &&
                  ((idx == 4 * VNU_GRP - 1) ? (vnu_ph == par_iter) : noise);
      if (start_mid && fsm == P_CNU && idx == 0 && vnu_ph == 0) start = 1'b1;
    end
    check({name, "_finished"}, finished, 1);
    check({name, "_load_cyc"}, n_load, exp_load);
    check({name, "_cnu_cyc"}, n_cnu, exp_cnu);
    check({name, "_vnu_cyc"}, n_vnu, exp_vnu);
    check({name, "_out_cyc"}, n_out, exp_out);
    check({name, "_in_beats"}, n_inbeat, LOAD_LEN);
    check({name, "_out_beats"}, n_outbeat, OUT_LEN);
    check({name, "_phase_bad"}, bad, 0);
    check({name, "_done_at_end"}, done, 1);
    check({name, "_done_count"}, done_seen, 1);
    check({name, "_iter"}, iter_cnt, exp_iter);
    check({name, "_early"}, early_term, exp_early);
    @(negedge clk);
    parity_ok = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check({name, "_done_low"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_iter_hold"}, iter_cnt, exp_iter);
    check({name, "_early_hold"}, early_term, exp_early);
  endtask

  initial begin
    bit hit;
    reset = 1'b1; start = 1'b0; rate = 1'b0; max_iter = 5'd0;
    in_valid = 1'b0; parity_ok = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_fsm", fsm, 0);
    check("rst_cycle", cycle, 0);
    check("rst_iter", iter_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_early", early_term, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    reset = 1'b0;

    // Asynchronous reset while in CNU, cycle 2.
    @(negedge clk);
    start = 1'b1; rate = 1'b0; max_iter = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (fsm == P_CNU && cycle == 2'd2) hit = 1;
    end
    check("midrst_reached", hit, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_fsm", fsm, 0);
    check("midrst_cycle", cycle, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    run_frame("full3",  1'b0, 5'd3, 0, 1'b1, 1'b0, 1'b0, 4, 24, 24, 2, 3, 0);
    run_frame("early2", 1'b0, 5'd3, 2, 1'b1, 1'b0, 1'b0, 4, 16, 16, 2, 2, 1);
    run_frame("rate1",  1'b1, 5'd1, 0, 1'b0, 1'b0, 1'b0, 4,  4,  8, 2, 1, 0);
    run_frame("max0",   1'b0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 4,  8,  8, 2, 1, 0);
    run_frame("toggle", 1'b0, 5'd1, 0, 1'b0, 1'b1, 1'b1, 7,  8,  8, 4, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
